fsm_decoder: RTL and testbench
==============================

FSM_DECODER -- requirements
Module: fsm_decoder

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 4: number of consecutive legal symbols before locked asserts (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of err_count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port y, input, 2 bits: encoded symbol from the x-to-y Mealy encoder.
REQ-006 SHALL have port y_valid, input, 1 bit: y is sampled only when high.
REQ-007 SHALL have port clr_cnt, input, 1 bit: synchronous clear of err_count.
REQ-008 SHALL have port x_out, output, 1 bit: recovered encoder input bit.
REQ-009 SHALL have port x_valid, output, 1 bit: one-cycle pulse qualifying x_out.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse for an illegal symbol.
REQ-011 SHALL have port err_count, output, CNT_W bits: saturating illegal-symbol count.
REQ-012 SHALL have port locked, output, 1 bit: high once LOCK_LEN consecutive legal symbols have been decoded.
REQ-013 SHALL have port state, output, 2 bits: tracked encoder state.

Function
REQ-014 SHALL track the encoder state in {S00=00, S01=01, S10=10}, starting at S00.
REQ-015 SHALL decode an accepted symbol (y_valid=1) as follows. S00: y=01 gives x=0 and next S00; y=00 gives x=1 and next S10. S01: y=00 gives x=0 and next S00; y=01 gives x=1 and next S01. S10: y=10 gives x=0 and next S01; y=00 gives x=1 and next S00.
REQ-016 SHALL register x_out and pulse x_valid on the clock edge that accepts a legal symbol; this is a latency of 1 cycle from y/y_valid to x_out/x_valid.
REQ-017 SHALL treat any other (state, y) pair as illegal. y=11 is always illegal.
REQ-018 On an illegal symbol SHALL pulse err for 1 cycle, keep x_valid=0, hold x_out, force the state to S00 (resync), clear the consecutive-legal count, and deassert locked.
REQ-019 With y_valid=0 SHALL hold the state, x_out, the count and locked, and drive x_valid=0 and err=0.
REQ-020 SHALL increment the consecutive-legal count on each legal symbol, saturating at LOCK_LEN, and assert locked while the count equals LOCK_LEN.
REQ-021 SHALL treat the unreachable state 11 as S00 for decoding, and leave it on the next clock edge even when y_valid=0.
REQ-022 SHALL increment err_count by 1 per illegal symbol and saturate at all-ones.
REQ-023 When clr_cnt and an illegal symbol occur in the same cycle, err_count SHALL become 0; clear wins.

Reset
REQ-024 While rst=1, asynchronously and regardless of clk: state=S00, x_out=0, x_valid=0, err=0, err_count=0, locked=0, consecutive count=0.
REQ-025 Reset asserted mid-stream SHALL discard any in-flight symbol; decoding restarts from S00 on the first clk edge after rst falls.

Configuration
REQ-026 Macro FSM_DECODER_ERRCNT_EN defined: err_count and clr_cnt behave per REQ-022/023.
REQ-027 Macro FSM_DECODER_ERRCNT_EN undefined: err_count tied to 0, clr_cnt ignored, no counter flops; all other behaviour unchanged.

Verification
REQ-028 After reset, stream y=00,10,00 with y_valid=1 -> x_out=1,0,0 with x_valid each cycle; state=S10,S01,S00; err=0.
REQ-029 From S00, y=10 -> err=1 for 1 cycle, x_valid=0, state=S00, err_count=1, locked=0.
REQ-030 4 legal symbols y=01,01,01,01 with LOCK_LEN=4 -> locked=1 after the 4th; then y=11 -> locked=0, err=1.
REQ-031 Illegal symbols 300 times with CNT_W=8 -> err_count=255; next cycle clr_cnt=1 together with y=11 -> err_count=0.
REQ-032 In S10 assert rst mid-cycle -> outputs zero immediately without a clk edge; after release y=01 -> x_out=0, state=S00.
REQ-033 Build without FSM_DECODER_ERRCNT_EN and repeat REQ-029 -> err pulses, err_count stays 0.

Source files
------------

// File: rtl/fsm_decoder.sv
// fsm_decoder: recovers the input bit x of a 3-state Mealy encoder from its
// 2-bit output symbol y, flags illegal symbols and reports lock status.
//
// Optional feature macro: FSM_DECODER_ERRCNT_EN
//   defined   -> saturating illegal-symbol counter on err_count, cleared by clr_cnt
//   undefined -> err_count tied to 0, clr_cnt ignored, no counter flops
//
// Ports
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous active-high reset
//   y[1:0]     in   encoded symbol
//   y_valid    in   y qualifier; y is sampled only when high
//   clr_cnt    in   synchronous clear of err_count
//   x_out      out  recovered encoder input bit (held between symbols)
//   x_valid    out  one-cycle pulse qualifying x_out
//   err        out  one-cycle pulse on an illegal symbol
//   err_count  out  saturating illegal-symbol count (CNT_W bits)
//   locked     out  high while LOCK_LEN consecutive legal symbols have been seen
//   state[1:0] out  tracked encoder state
module fsm_decoder #(
    parameter int unsigned LOCK_LEN = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       y,
    input  logic             y_valid,
    input  logic             clr_cnt,
    output logic             x_out,
    output logic             x_valid,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic             locked,
    output logic [1:0]       state
);

    localparam int unsigned LCNT_W   = 4;
    localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_LEN);

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } state_t;

    state_t            r_state;
    logic              r_x_out;
    logic              r_x_valid;
    logic              r_err;
    logic              r_locked;
    logic [LCNT_W-1:0] r_lcnt;

    logic              w_legal;
    logic              w_x;
    state_t            w_next;
    logic [LCNT_W-1:0] w_lcnt_inc;

    // Symbol decode; the unreachable state 11 decodes like S00.
    always_comb begin
        w_legal = 1'b0;
        w_x     = 1'b0;
        w_next  = S00;
        case (r_state)
            S01: begin
                if (y == 2'b00) begin
                    w_legal = 1'b1; w_x = 1'b0; w_next = S00;
                end else if (y == 2'b01) begin
                    w_legal = 1'b1; w_x = 1'b1; w_next = S01;
                end
            end
            S10: begin
                if (y == 2'b10) begin
                    w_legal = 1'b1; w_x = 1'b0; w_next = S01;
                end else if (y == 2'b00) begin
                    w_legal = 1'b1; w_x = 1'b1; w_next = S00;
                end
            end
            default: begin
                if (y == 2'b01) begin
                    w_legal = 1'b1; w_x = 1'b0; w_next = S00;
                end else if (y == 2'b00) begin
                    w_legal = 1'b1; w_x = 1'b1; w_next = S10;
                end
            end
        endcase
    end

    // Consecutive-legal count, saturating at LOCK_MAX.
    always_comb begin
        w_lcnt_inc = r_lcnt;
        if (r_lcnt != LOCK_MAX) begin
            w_lcnt_inc = r_lcnt + LCNT_W'(1);
        end
    end

    // Decoder state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S00;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_lcnt    <= '0;
        end else begin
            r_x_valid <= 1'b0;
            r_err     <= 1'b0;
            if (y_valid) begin
                if (w_legal) begin
                    r_state   <= w_next;
                    r_x_out   <= w_x;
                    r_x_valid <= 1'b1;
                    r_lcnt    <= w_lcnt_inc;
                    r_locked  <= (w_lcnt_inc == LOCK_MAX);
                end else begin
                    // Illegal symbol: resync to S00 and drop lock.
                    r_state  <= S00;
                    r_err    <= 1'b1;
                    r_lcnt   <= '0;
                    r_locked <= 1'b0;
                end
            end else if (r_state == S11) begin
                r_state <= S00;
            end
        end
    end

`ifdef FSM_DECODER_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Illegal-symbol counter; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (clr_cnt) begin
            r_err_count <= '0;
        end else if (y_valid && !w_legal && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt;
    assign err_count    = '0;
`endif

    assign x_out   = r_x_out;
    assign x_valid = r_x_valid;
    assign err     = r_err;
    assign locked  = r_locked;
    assign state   = r_state;

endmodule

// File: tb/tb_fsm_decoder.sv
// Directed testbench for fsm_decoder (LOCK_LEN=4, CNT_W=8). Expected err_count
// values follow whether FSM_DECODER_ERRCNT_EN is defined for the build.
module tb_fsm_decoder;

    localparam int unsigned CNT_W = 8;
`ifdef FSM_DECODER_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [1:0]       y;
    logic             y_valid;
    logic             clr_cnt;
    logic             x_out;
    logic             x_valid;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic             locked;
    logic [1:0]       state;

    int n_pass;
    int n_total;

    fsm_decoder #(.LOCK_LEN(4), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .y_valid   (y_valid),
        .clr_cnt   (clr_cnt),
        .x_out     (x_out),
        .x_valid   (x_valid),
        .err       (err),
        .err_count (err_count),
        .locked    (locked),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {x_out, x_valid, err, locked, state}.
    function automatic logic [5:0] obs();
        return {x_out, x_valid, err, locked, state};
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int v);
        return CNT_EN ? CNT_W'(v) : '0;
    endfunction

    // Apply one symbol, then sample 1 time unit after the accepting edge.
    task automatic cyc(input logic [1:0] yy, input logic v, input logic c);
        y = yy; y_valid = v; clr_cnt = c;
        @(posedge clk);
        #1;
        y_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; y = 2'b00; y_valid = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [5:0] exp);
        // single-purpose formatting of the packed status vector is done inline by callers
        n_total++;
        if (obs() !== exp) $display("FAIL %s: got %b want %b", name, obs(), exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; y = 2'b00; y_valid = 1'b0; clr_cnt = 1'b0;
        #2;
        n_total++;
        if (obs() !== 6'b000000) $display("FAIL reset_status: got %b want %b", obs(), 6'b000000);
        else n_pass++;
        n_total++;
        if (err_count !== '0) $display("FAIL reset_errcnt: got %0d want 0", err_count);
        else n_pass++;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_decode();
        do_reset();
        cyc(2'b00, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b110010) $display("FAIL dec_s00_y00: got %b want %b", obs(), 6'b110010);
        else n_pass++;
        cyc(2'b10, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b010001) $display("FAIL dec_s10_y10: got %b want %b", obs(), 6'b010001);
        else n_pass++;
        cyc(2'b00, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b010000) $display("FAIL dec_s01_y00: got %b want %b", obs(), 6'b010000);
        else n_pass++;
        // S00 -> S10 -> S01 (x=1,0 then lock at 4th), S01 y=01 stays S01 with x=1
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b10, 1'b1, 1'b0);
        cyc(2'b01, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b110101) $display("FAIL dec_s01_y01: got %b want %b", obs(), 6'b110101);
        else n_pass++;
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b110110) $display("FAIL dec_s10_entry: got %b want %b", obs(), 6'b110110);
        else n_pass++;
        cyc(2'b00, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b110100) $display("FAIL dec_s10_y00: got %b want %b", obs(), 6'b110100);
        else n_pass++;
    endtask

    task automatic test_idle();
        do_reset();
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        n_total++;
        if (obs() !== 6'b100010) $display("FAIL idle_hold: got %b want %b", obs(), 6'b100010);
        else n_pass++;
        n_total++;
        if (err_count !== '0) $display("FAIL idle_errcnt: got %0d want 0", err_count);
        else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        cyc(2'b10, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b001000) $display("FAIL illegal_s00_y10: got %b want %b", obs(), 6'b001000);
        else n_pass++;
        n_total++;
        if (err_count !== exp_cnt(1)) $display("FAIL illegal_errcnt: got %0d want %0d", err_count, exp_cnt(1));
        else n_pass++;
        cyc(2'b00, 1'b0, 1'b0);
        n_total++;
        if (obs() !== 6'b000000) $display("FAIL illegal_pulse_end: got %b want %b", obs(), 6'b000000);
        else n_pass++;
        // Illegal in S10 holds x_out=1 and resyncs to S00
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b01, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b101000) $display("FAIL illegal_s10_y01: got %b want %b", obs(), 6'b101000);
        else n_pass++;
        n_total++;
        if (err_count !== exp_cnt(2)) $display("FAIL illegal_errcnt2: got %0d want %0d", err_count, exp_cnt(2));
        else n_pass++;
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(2'b01, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b010000) $display("FAIL lock_after3: got %b want %b", obs(), 6'b010000);
        else n_pass++;
        cyc(2'b01, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b010100) $display("FAIL lock_after4: got %b want %b", obs(), 6'b010100);
        else n_pass++;
        cyc(2'b01, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b010100) $display("FAIL lock_after5: got %b want %b", obs(), 6'b010100);
        else n_pass++;
        cyc(2'b11, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b001000) $display("FAIL lock_drop_y11: got %b want %b", obs(), 6'b001000);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) cyc(2'b11, 1'b1, 1'b0);
        n_total++;
        if (err_count !== exp_cnt(10)) $display("FAIL errcnt_10: got %0d want %0d", err_count, exp_cnt(10));
        else n_pass++;
        for (int i = 0; i < 290; i++) cyc(2'b11, 1'b1, 1'b0);
        n_total++;
        if (err_count !== exp_cnt(255)) $display("FAIL errcnt_sat: got %0d want %0d", err_count, exp_cnt(255));
        else n_pass++;
        cyc(2'b11, 1'b1, 1'b1);
        n_total++;
        if (err_count !== '0) $display("FAIL errcnt_clr_wins: got %0d want 0", err_count);
        else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("FAIL errcnt_clr_err: got %b want 1", err);
        else n_pass++;
        cyc(2'b11, 1'b1, 1'b0);
        n_total++;
        if (err_count !== exp_cnt(1)) $display("FAIL errcnt_resume: got %0d want %0d", err_count, exp_cnt(1));
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(2'b00, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b110010) $display("FAIL arst_pre: got %b want %b", obs(), 6'b110010);
        else n_pass++;
        // In-flight symbol presented, then reset mid-cycle without a clock edge
        y = 2'b10; y_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (obs() !== 6'b000000) $display("FAIL arst_async: got %b want %b", obs(), 6'b000000);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2'b01, 1'b1, 1'b0);
        n_total++;
        if (obs() !== 6'b010000) $display("FAIL arst_restart: got %b want %b", obs(), 6'b010000);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; y = 2'b00; y_valid = 1'b0; clr_cnt = 1'b0;
        test_reset();
        test_decode();
        test_idle();
        test_illegal();
        test_lock();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
